// File: rtl/onehot_demultiplexer_buffered_if.sv
// Handshake bundle for the buffered one-hot demultiplexer.
// Master drives the upstream beat and downstream ready; slave is the demux.
interface onehot_demultiplexer_buffered_if #(
  parameter int SEL_WIDTH = 2,
  parameter int WIDTH     = 1
);
  logic                       i_valid;
  logic [WIDTH-1:0]           i_data;
  logic [SEL_WIDTH-1:0]       i_sel;
  logic                       o_ready;
  logic [SEL_WIDTH-1:0]       o_valid;
  logic [SEL_WIDTH*WIDTH-1:0] o_data;
  logic [SEL_WIDTH-1:0]       i_ready;
  logic                       o_err;
  logic [7:0]                 o_err_cnt;

  modport master (
    output i_valid, i_data, i_sel, i_ready,
    input  o_ready, o_valid, o_data, o_err, o_err_cnt
  );

  modport slave (
    input  i_valid, i_data, i_sel, i_ready,
    output o_ready, o_valid, o_data, o_err, o_err_cnt
  );
endinterface

// File: rtl/onehot_demultiplexer_buffered.sv
// One-hot demux behind a 2-entry FIFO; illegal selects are dropped and
// counted. Output data uses the channel-major packing of the one-hot mux.
module onehot_demultiplexer_buffered #(
  parameter int SEL_WIDTH = 2,
  parameter int WIDTH     = 1
) (
  input  logic clk,
  input  logic reset_n,
  onehot_demultiplexer_buffered_if.slave bus
);
  localparam logic [SEL_WIDTH-1:0] ONE = SEL_WIDTH'(1);

  logic [WIDTH-1:0]           mem_data [2];
  logic [SEL_WIDTH-1:0]       mem_sel  [2];
  logic                       head;
  logic                       tail;
  logic [1:0]                 count;
  logic [1:0]                 count_nx;
  logic                       ready_q;
  logic                       err_q;
  logic [7:0]                 cnt_q;
  logic                       legal;
  logic                       accept;
  logic                       push;
  logic                       pop;
  logic [SEL_WIDTH-1:0]       vld;
  logic [SEL_WIDTH*WIDTH-1:0] dat;

  assign legal  = (bus.i_sel != '0) &&
                  ((bus.i_sel & (bus.i_sel - ONE)) == '0);
  assign accept = bus.i_valid & ready_q;
  assign push   = accept & legal;
  assign pop    = |(vld & bus.i_ready);

  always_comb begin
    count_nx = count;
    unique case (1'b1)
      push & ~pop: count_nx = count + 2'd1;
      pop & ~push: count_nx = count - 2'd1;
      default:     count_nx = count;
    endcase
  end

  // Stored selects are always one-hot, so at most one slice is filled.
  always_comb begin
    vld = '0;
    dat = '0;
    if (count != 2'd0) begin
      vld = mem_sel[head];
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (mem_sel[head][k]) dat[k*WIDTH +: WIDTH] = mem_data[head];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_sel[i]  <= '0;
      end
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      if (push) begin
        mem_data[tail] <= bus.i_data;
        mem_sel[tail]  <= bus.i_sel;
        tail           <= ~tail;
      end
      if (pop) head <= ~head;
      count   <= count_nx;
      ready_q <= (count_nx != 2'd2);
      err_q   <= accept & ~legal;
      if (accept & ~legal & (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = vld;
  assign bus.o_data    = dat;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = cnt_q;
endmodule

// File: tb/tb_onehot_demultiplexer_buffered.sv
// Directed bench for onehot_demultiplexer_buffered, SEL_WIDTH=4, WIDTH=8.
module tb_onehot_demultiplexer_buffered;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  onehot_demultiplexer_buffered_if #(.SEL_WIDTH(4), .WIDTH(8)) bus ();

  onehot_demultiplexer_buffered #(.SEL_WIDTH(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic [3:0] s);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_sel   = s;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 4'h0);
    bus.i_ready = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 4'h0 ||
        bus.o_data !== 32'h0 || bus.o_err !== 1'b0 ||
        bus.o_err_cnt !== 8'h0) begin
      failures++;
      $display("FAIL reset_outs rdy=%b vld=%h dat=%h err=%b cnt=%h want all 0",
               bus.o_ready, bus.o_valid, bus.o_data, bus.o_err,
               bus.o_err_cnt);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", bus.o_ready);
    end
    step();
    checks++;
    if (bus.o_valid !== 4'h0 || bus.o_data !== 32'h0) begin
      failures++;
      $display("FAIL idle_valid vld=%h dat=%h want 0", bus.o_valid,
               bus.o_data);
    end
  endtask

  task automatic test_stream();
    logic [7:0]  dv [4];
    logic [3:0]  sv [4];
    logic [31:0] exp;
    dv = '{8'h11, 8'h22, 8'h33, 8'h44};
    sv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.i_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dv[i], sv[i]);
      step();
      exp = 32'(dv[i]) << (8 * i);
      checks++;
      if (bus.o_valid !== sv[i] || bus.o_data !== exp ||
          bus.o_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d vld=%h dat=%h rdy=%b want %h %h 1",
                 i, bus.o_valid, bus.o_data, bus.o_ready, sv[i], exp);
      end
    end
    drive(1'b0, 8'h00, 4'h0);
    step();
    checks++;
    if (bus.o_valid !== 4'h0 || bus.o_data !== 32'h0) begin
      failures++;
      $display("FAIL stream_drain vld=%h dat=%h want 0", bus.o_valid,
               bus.o_data);
    end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 4'h0;
    drive(1'b1, 8'hA1, 4'b0100);
    step();
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_data !== 32'h00A1_0000) begin
      failures++;
      $display("FAIL bp_first rdy=%b dat=%h want 1 00a10000",
               bus.o_ready, bus.o_data);
    end
    drive(1'b1, 8'hA2, 4'b0100);
    step();
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 4'b0100) begin
      failures++;
      $display("FAIL bp_full rdy=%b vld=%h want 0 4", bus.o_ready,
               bus.o_valid);
    end
    drive(1'b1, 8'hA3, 4'b0100);
    step();
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_data !== 32'h00A1_0000) begin
      failures++;
      $display("FAIL bp_hold rdy=%b dat=%h want 0 00a10000",
               bus.o_ready, bus.o_data);
    end
    bus.i_ready = 4'b0100;
    step();
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_data !== 32'h00A2_0000) begin
      failures++;
      $display("FAIL bp_pop1 rdy=%b dat=%h want 1 00a20000",
               bus.o_ready, bus.o_data);
    end
    step();
    drive(1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.o_data !== 32'h00A3_0000 || bus.o_valid !== 4'b0100) begin
      failures++;
      $display("FAIL bp_pop2 dat=%h vld=%h want 00a30000 4",
               bus.o_data, bus.o_valid);
    end
    step();
    checks++;
    if (bus.o_valid !== 4'h0 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_empty vld=%h rdy=%b want 0 1", bus.o_valid,
               bus.o_ready);
    end
  endtask

  task automatic test_hol();
    bus.i_ready = 4'b0010;
    drive(1'b1, 8'h55, 4'b0001);
    step();
    drive(1'b1, 8'h66, 4'b0010);
    step();
    drive(1'b0, 8'h00, 4'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_valid !== 4'b0001 || bus.o_data !== 32'h0000_0055) begin
        failures++;
        $display("FAIL hol_block_%0d vld=%h dat=%h want 1 00000055",
                 i, bus.o_valid, bus.o_data);
      end
      step();
    end
    bus.i_ready = 4'b0011;
    step();
    checks++;
    if (bus.o_valid !== 4'b0010 || bus.o_data !== 32'h0000_6600) begin
      failures++;
      $display("FAIL hol_release vld=%h dat=%h want 2 00006600",
               bus.o_valid, bus.o_data);
    end
    step();
    checks++;
    if (bus.o_valid !== 4'h0) begin
      failures++;
      $display("FAIL hol_empty vld=%h want 0", bus.o_valid);
    end
  endtask

  task automatic test_illegal();
    bus.i_ready = 4'hF;
    drive(1'b1, 8'h77, 4'b0000);
    step();
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_err_cnt !== 8'd1 ||
        bus.o_valid !== 4'h0) begin
      failures++;
      $display("FAIL ill_zero err=%b cnt=%0d vld=%h want 1 1 0",
               bus.o_err, bus.o_err_cnt, bus.o_valid);
    end
    drive(1'b1, 8'h78, 4'b0110);
    step();
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_err_cnt !== 8'd2 ||
        bus.o_valid !== 4'h0) begin
      failures++;
      $display("FAIL ill_multi err=%b cnt=%0d vld=%h want 1 2 0",
               bus.o_err, bus.o_err_cnt, bus.o_valid);
    end
    drive(1'b1, 8'h99, 4'b1000);
    step();
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_err_cnt !== 8'd2 ||
        bus.o_valid !== 4'b1000 || bus.o_data !== 32'h9900_0000) begin
      failures++;
      $display("FAIL ill_legal err=%b cnt=%0d vld=%h dat=%h want 0 2 8 99000000",
               bus.o_err, bus.o_err_cnt, bus.o_valid, bus.o_data);
    end
    drive(1'b1, 8'h00, 4'b0000);
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (bus.o_err_cnt !== 8'd255 || bus.o_err !== 1'b1 ||
        bus.o_valid !== 4'h0) begin
      failures++;
      $display("FAIL ill_sat cnt=%0d err=%b vld=%h want 255 1 0",
               bus.o_err_cnt, bus.o_err, bus.o_valid);
    end
    drive(1'b0, 8'h00, 4'h0);
    step();
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL ill_idle err=%b cnt=%0d want 0 255", bus.o_err,
               bus.o_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 4'h0;
    drive(1'b1, 8'hC1, 4'b0001);
    step();
    drive(1'b1, 8'hC2, 4'b0010);
    step();
    drive(1'b0, 8'h00, 4'h0);
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 4'b0001) begin
      failures++;
      $display("FAIL mid_full rdy=%b vld=%h want 0 1", bus.o_ready,
               bus.o_valid);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 4'h0 || bus.o_data !== 32'h0 ||
        bus.o_err_cnt !== 8'h0 || bus.o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_async vld=%h dat=%h cnt=%0d rdy=%b want 0 0 0 0",
               bus.o_valid, bus.o_data, bus.o_err_cnt, bus.o_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.i_ready = 4'hF;
    step();
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 4'h0) begin
      failures++;
      $display("FAIL mid_release rdy=%b vld=%h want 1 0", bus.o_ready,
               bus.o_valid);
    end
    step();
    checks++;
    if (bus.o_valid !== 4'h0 || bus.o_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_stale vld=%h dat=%h want 0 0", bus.o_valid,
               bus.o_data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_hol();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/onehot_demultiplexer_buffered.md
# onehot_demultiplexer_buffered

Buffered one-hot demultiplexer: accepts a single valid/ready input stream whose beats carry a one-hot destination select, and steers each beat to exactly one of SEL_WIDTH output channels. Output data is packed in the same channel-major layout the one-hot multiplexer consumes, so the two blocks form a matched fan-out/fan-in pair around a set of parallel units. A 2-entry FIFO decouples the upstream and downstream handshakes; beats with an illegal select are consumed, dropped and counted.

## Interface
- SEL_WIDTH, 2, number of output channels; also the width of the one-hot select.
- WIDTH, 1, data width per channel.

- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream beat valid.
- i_data  input  WIDTH  upstream beat data.
- i_sel  input  SEL_WIDTH  one-hot destination of the upstream beat.
- o_ready  output  1  upstream ready; registered.
- o_valid  output  SEL_WIDTH  per-channel valid; bit k high only for channel k.
- o_data  output  SEL_WIDTH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]; unselected slices forced to 0.
- i_ready  input  SEL_WIDTH  per-channel downstream ready.
- o_err  output  1  one-cycle pulse: an illegal-select beat was dropped.
- o_err_cnt  output  8  saturating count of dropped beats.

## Operation
- Storage: 2-entry FIFO, each entry holds {data, sel}; count register 0..2; head/tail pointers wrap modulo 2.
- Push: i_valid & o_ready. Only legal beats are pushed, meaning exactly one bit of i_sel set.
- Illegal beat: i_sel zero or multi-hot, accepted while i_valid & o_ready.
  - Consumed upstream and not stored.
  - o_err = 1 the following cycle.
  - o_err_cnt increments by 1 and saturates at 255.
- Head presentation, count > 0: o_valid = head.sel and o_data slice k = head.data for the set bit k; all other slices 0.
- Count = 0: o_valid = 0 and o_data = 0.
- Pop: |(o_valid & i_ready). Only the selected channel's ready matters; ready on other channels is ignored.
- Ordering: strict FIFO across all channels. A stalled head blocks later beats even when they target a ready channel (head-of-line blocking by design).
- Simultaneous push and pop: count unchanged, both pointers advance. A pop on an empty FIFO is impossible because o_valid is 0.
- o_ready next = (count_next < 2).
- The same cycle may pop a legal head and accept an illegal beat: pop proceeds, error logic updates, count decrements.

## Timing
- Reset (asynchronous assert) drives:
  - count = 0, pointers = 0.
  - o_valid = 0, o_data = 0.
  - o_ready = 0, o_err = 0, o_err_cnt = 0.
- First rising edge after reset_n deasserts: o_ready goes to 1.
- Latency: a beat accepted at edge N is visible on o_valid/o_data after edge N; downstream may take it at edge N+1.
- Throughput: 1 beat/cycle sustained when the selected downstream ready is held high.
- Full: count = 2 means o_ready = 0 from the same edge. o_ready returns to 1 on the edge after the pop that frees an entry; no combinational ready path exists.
- o_err pulses for exactly one cycle per illegal beat. Back-to-back illegal beats keep it high on consecutive cycles.
- Reset asserted mid-stream discards FIFO contents and clears the error counter immediately, without waiting for a clock.
- No X propagation: o_data unselected slices must be 0 in every cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold reset_n = 0, then release.
  - Required response: all outputs are 0 during reset; o_ready = 1 one edge after release; o_valid stays 0 with no input.
- Streaming, SEL_WIDTH = 4, WIDTH = 8, all i_ready high:
  - Stimulus: beats 0x11/0001, 0x22/0010, 0x33/0100, 0x44/1000 on consecutive cycles.
  - Required response: each beat appears on the matching channel one cycle later; other slices are 0; no bubbles.
- Backpressure and full:
  - Stimulus: i_ready = 0; push 3 beats targeting channel 2.
  - Required response: o_ready falls after the 2nd accept; the 3rd beat is held upstream. Raise i_ready[2]: beats drain in order, o_ready returns the edge after the first pop.
- Head-of-line blocking:
  - Stimulus: head targets channel 0 with i_ready[0] = 0; next beat targets channel 1 with i_ready[1] = 1.
  - Required response: o_valid = 0001 and holds; channel 1 receives nothing until i_ready[0] rises.
- Illegal select:
  - Stimulus: push i_sel = 0000, then 0110, then a legal beat.
  - Required response: o_err high for 2 cycles; o_err_cnt = 2; only the legal beat is delivered. Then push 300 illegal beats: o_err_cnt saturates at 255.
- Reset mid-operation:
  - Stimulus: FIFO holds 2 beats; assert reset_n = 0 between edges.
  - Required response: o_valid and count clear immediately; after release no stale beat appears.
